cur_block_fetch: RTL and testbench

Fetches the 16x16 luma current block at the block position given by the motion-estimation controller from external frame memory into the current-block buffer, then signals `currentfilled`. It sits directly upstream of the ME controller's FillCurrent state: the controller drives `start` and `curpos`, and this block answers with `currentfilled`. Memory reads are pipelined with a bounded number of outstanding requests.

---
 rtl/cur_block_fetch.sv | 126 ++++++++++++
 tb/tb_cur_block_fetch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cur_block_fetch.sv
// Fetches the 16x16 luma current block from frame memory into the current-block buffer.
// Optional CUR_FETCH_SUM_EN builds a pixel-sum accumulator driving blk_sum_o.
module cur_block_fetch #(
  parameter int unsigned FRAME_W_WORDS = 320,
  parameter int unsigned AW            = 18,
  parameter int unsigned MAX_OUT       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [13:0]   curpos_i,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i,
  output logic          buf_we_o,
  output logic [5:0]    buf_waddr_o,
  output logic [31:0]   buf_wdata_o,
  output logic          currentfilled_o,
  output logic [15:0]   blk_sum_o
);

  localparam int unsigned OutW = $clog2(MAX_OUT + 1);
  localparam logic [AW-1:0] RowStride = AW'(FRAME_W_WORDS);
  localparam logic [AW-1:0] BlkStride = AW'(16 * FRAME_W_WORDS);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [5:0]      iss_q, iss_d;
  logic [5:0]      ret_q, ret_d;
  logic [OutW-1:0] out_q, out_d;
  logic            grant;

  // Address depends only on registered state, so it cannot move until a grant bumps iss.
  assign mem_addr_o      = base_q + AW'(iss_q[5:2]) * RowStride + AW'(iss_q[1:0]);
  assign buf_waddr_o     = ret_q;
  assign buf_wdata_o     = mem_rdata_i;
  assign currentfilled_o = (state_q == StDone);
  assign grant           = mem_req_o && mem_gnt_i;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    iss_d     = iss_q;
    ret_d     = ret_q;
    out_d     = out_q;
    mem_req_o = 1'b0;
    buf_we_o  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d  = AW'(curpos_i[13:7]) * BlkStride + AW'({curpos_i[6:0], 2'b00});
          iss_d   = '0;
          ret_d   = '0;
          out_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // A same-cycle return frees a slot, so issue may proceed even at the limit.
        mem_req_o = (out_q < OutW'(MAX_OUT)) || mem_rvalid_i;
        buf_we_o  = mem_rvalid_i;
        if (mem_req_o && mem_gnt_i) begin
          iss_d = iss_q + 6'd1;
          if (iss_q == 6'd63) state_d = StDrain;
        end
      end
      StDrain: begin
        buf_we_o = mem_rvalid_i;
        if (mem_rvalid_i && ret_q == 6'd63) state_d = StDone;
      end
      StDone: begin
        if (!start_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (buf_we_o) ret_d = ret_q + 6'd1;
    if (grant && !buf_we_o) out_d = out_q + OutW'(1);
    if (!grant && buf_we_o) out_d = out_q - OutW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      base_q  <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      out_q   <= out_d;
    end
  end

`ifdef CUR_FETCH_SUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == StIdle && start_i) begin
      sum_d = '0;
    end else if (buf_we_o) begin
      sum_d = sum_q + 16'(mem_rdata_i[7:0]) + 16'(mem_rdata_i[15:8])
                    + 16'(mem_rdata_i[23:16]) + 16'(mem_rdata_i[31:24]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign blk_sum_o = sum_q;
`else
  assign blk_sum_o = '0;
`endif

endmodule

// File: tb/tb_cur_block_fetch.sv
// Self-checking bench for cur_block_fetch: in-order latency memory model plus a
// per-cycle scoreboard derived from the block/address arithmetic.
module tb_cur_block_fetch;
  localparam int unsigned FW  = 320;
  localparam int unsigned AWP = 18;
  localparam int unsigned MO  = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [13:0]    curpos = '0;
  logic           mem_req;
  logic [AWP-1:0] mem_addr;
  logic           mem_gnt = 1'b0;
  logic           mem_rvalid = 1'b0;
  logic [31:0]    mem_rdata = '0;
  logic           buf_we;
  logic [5:0]     buf_waddr;
  logic [31:0]    buf_wdata;
  logic           currentfilled;
  logic [15:0]    blk_sum;

  cur_block_fetch #(
    .FRAME_W_WORDS(FW),
    .AW           (AWP),
    .MAX_OUT      (MO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start),
    .curpos_i       (curpos),
    .mem_req_o      (mem_req),
    .mem_addr_o     (mem_addr),
    .mem_gnt_i      (mem_gnt),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata),
    .buf_we_o       (buf_we),
    .buf_waddr_o    (buf_waddr),
    .buf_wdata_o    (buf_wdata),
    .currentfilled_o(currentfilled),
    .blk_sum_o      (blk_sum)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int lat = 2, gmode = 0, dmode = 0;
  logic [AWP-1:0] rq_addr[$];
  int             rq_due[$];

  int exp_base = 0;
  bit armed = 0, active = 0, exp_cf = 0, pend = 0;
  int grants = 0, writes = 0, peak = 0;
  logic [15:0]    msum = '0;
  logic [AWP-1:0] held_addr = '0;
  logic [AWP-1:0] first_addr = '0, last_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [AWP-1:0] a);
    int col;
    case (dmode)
      1: return 32'hFFFF_FFFF;
      2: begin
        col = (int'(a) % FW) * 4;
        return {8'(col + 3), 8'(col + 2), 8'(col + 1), 8'(col)};
      end
      default: return ({14'b0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [AWP-1:0] exp_addr(input int k);
    int v;
    v = exp_base + (k / 4) * FW + (k % 4);
    return AWP'(v);
  endfunction

  function automatic logic [15:0] exp_sum();
`ifdef CUR_FETCH_SUM_EN
    return msum;
`else
    return 16'd0;
`endif
  endfunction

  // Scoreboard: every cycle, compare DUT outputs with what the block rules demand.
  always @(negedge clk) begin
    if (!reset) begin
      int          mout;
      logic        exp_req;
      logic [31:0] w;
      mout    = grants - writes;
      exp_req = active && ((mout < MO) || mem_rvalid);
      check("mem_req", mem_req, exp_req);
      if (pend && mem_req) check("addr_hold", mem_addr, held_addr);
      if (mem_req && mem_gnt) begin
        check("mem_addr", mem_addr, exp_addr(grants));
        if (grants == 0) first_addr = mem_addr;
        last_addr = mem_addr;
        rq_addr.push_back(mem_addr);
        rq_due.push_back(cyc + lat);
        grants++;
        if (grants == 64) active = 0;
      end
      pend      = mem_req && !mem_gnt;
      held_addr = mem_addr;
      check("buf_we", buf_we, mem_rvalid);
      if (buf_we) begin
        w = memfn(exp_addr(writes));
        check("buf_waddr", buf_waddr, writes);
        check("buf_wdata", buf_wdata, w);
        msum = msum + 16'(w[7:0]) + 16'(w[15:8]) + 16'(w[23:16]) + 16'(w[31:24]);
        writes++;
      end
      if (grants - writes > peak) peak = grants - writes;
      check("currentfilled", currentfilled, exp_cf);
      if (exp_cf) check("blk_sum", blk_sum, exp_sum());
      if (exp_cf && !start) exp_cf = 0;
      if (buf_we && writes == 64) exp_cf = 1;
      if (armed) begin
        active = 1;
        armed  = 0;
      end
    end
  end

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    mem_gnt = (gmode == 0) ? 1'b1 : ((cyc % 2) == 0);
    if (rq_due.size() > 0 && rq_due[0] == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = memfn(rq_addr[0]);
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic begin_run(input logic [13:0] pos, input int l, input int g, input int d);
    curpos   = pos;
    lat      = l;
    gmode    = g;
    dmode    = d;
    exp_base = int'(pos[13:7]) * 16 * FW + int'(pos[6:0]) * 4;
    grants   = 0;
    writes   = 0;
    peak     = 0;
    msum     = '0;
    pend     = 0;
    drive_cycle();
    start = 1'b1;
    armed = 1;
  endtask

  task automatic run_block(input logic [13:0] pos, input int l, input int g, input int d,
                           input int drop_at, input string tag,
                           output int rise, output logic [15:0] sum_at_rise);
    int t0;
    begin_run(pos, l, g, d);
    t0   = cyc;
    rise = -1;
    sum_at_rise = '0;
    for (int i = 0; i < 3000; i++) begin
      drive_cycle();
      if (cyc - t0 == drop_at) start = 1'b0;
      if (currentfilled) begin
        rise = cyc - t0;
        sum_at_rise = blk_sum;
        break;
      end
    end
    check({tag, "_filled"}, currentfilled, 1'b1);
    check({tag, "_grants"}, grants, 64);
    check({tag, "_writes"}, writes, 64);
    if (start) drive_cycle();
    start = 1'b0;
    drive_cycle();
    drive_cycle();
    check({tag, "_cf_low"}, currentfilled, 1'b0);
  endtask

  initial begin
    int          rise;
    logic [15:0] s;
`ifdef CUR_FETCH_SUM_EN
    logic [15:0] sum_ff  = 16'd65280;
    logic [15:0] sum_col = 16'd1920;
`else
    logic [15:0] sum_ff  = 16'd0;
    logic [15:0] sum_col = 16'd0;
`endif

    @(posedge clk);
    #1;
    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 0);
    check("rst_we", buf_we, 1'b0);
    check("rst_cf", currentfilled, 1'b0);
    check("rst_sum", blk_sum, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Origin block, latency 2: one request per cycle.
    run_block(14'd0, 2, 0, 0, -1, "t1", rise, s);
    check("t1_first_addr", first_addr, 0);
    check("t1_last_addr", last_addr, 4803);
    check("t1_rise_cycle", rise, 67);

    // Bottom-right block.
    run_block({7'd44, 7'd79}, 2, 0, 0, -1, "t2", rise, s);
    check("t2_first_addr", first_addr, 225596);
    check("t2_last_addr", last_addr, 230399);

    // Toggling grant, latency 3, start dropped mid-fetch (pulse on completion).
    run_block({7'd7, 7'd21}, 3, 1, 0, 5, "t3", rise, s);

    // Latency 8 exceeds the outstanding budget: issue must stall at MAX_OUT.
    run_block({7'd3, 7'd10}, 8, 0, 0, -1, "t4", rise, s);
    check("t4_peak_out", peak, MO);

    // Sum with all-0xFF pixels, then column-index pixels.
    run_block({7'd2, 7'd0}, 2, 0, 1, -1, "t5a", rise, s);
    check("t5a_sum_at_fill", s, sum_ff);
    check("t5a_sum_held", blk_sum, sum_ff);
    run_block({7'd2, 7'd0}, 2, 0, 2, -1, "t5b", rise, s);
    check("t5b_sum_at_fill", s, sum_col);
    check("t5b_sum_held", blk_sum, sum_col);

    // Reset at request 30, then refetch from a new position.
    begin_run({7'd5, 7'd20}, 2, 0, 0);
    for (int i = 0; i < 200; i++) begin
      drive_cycle();
      if (grants >= 30) break;
    end
    check("t6_grants_before_reset", grants, 30);
    reset = 1'b1;
    #1;
    check("t6_rst_req", mem_req, 1'b0);
    check("t6_rst_addr", mem_addr, 0);
    check("t6_rst_we", buf_we, 1'b0);
    check("t6_rst_waddr", buf_waddr, 0);
    check("t6_rst_cf", currentfilled, 1'b0);
    check("t6_rst_sum", blk_sum, 0);
    rq_addr.delete();
    rq_due.delete();
    mem_rvalid = 1'b0;
    start  = 1'b0;
    active = 0;
    armed  = 0;
    exp_cf = 0;
    pend   = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_block({7'd9, 7'd33}, 2, 0, 0, -1, "t6", rise, s);
    check("t6_first_addr", first_addr, 9 * 5120 + 33 * 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
